// File: rtl/inventory_txn_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : inventory_txn_sequencer_if
// Description : Request/response handshake bundle for the inventory
//               transaction sequencer.
//               master : issues requests, consumes responses
//               slave  : the sequencer itself
//   req_valid/req_ready/req_op/req_qty/req_uprice : request channel
//   rsp_valid/rsp_ready/rsp_status/rsp_price      : response channel
// Revision    : 1.0 - initial release
// ============================================================================
interface inventory_txn_sequencer_if #(
    parameter int QW = 4,
    parameter int UW = 4,
    parameter int PW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic [QW-1:0] req_qty;
    logic [UW-1:0] req_uprice;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_status;
    logic [PW-1:0] rsp_price;

    modport master (
        output req_valid, req_op, req_qty, req_uprice, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_price
    );

    modport slave (
        input  req_valid, req_op, req_qty, req_uprice, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_price
    );
endinterface
`default_nettype wire

// File: rtl/inventory_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : inventory_txn_sequencer
// Description : Owns the stock count and cash balance. Accepts one sell or
//               restock request at a time, forms price = qty * unit_price
//               with a bit-serial shift-add multiplier, checks stock/funds/
//               overflow, commits atomically and returns a status.
//   clk, reset        : clock, synchronous active-high reset
//   init_load/_count/_balance : load count/balance (IDLE only, wins over req)
//   bus (slave)       : request and response handshakes
//   count, balance    : current registered state
//   empty             : count == 0
//   Status codes: 0 OK, 1 NO_STOCK, 2 NO_FUNDS, 3 OVERFLOW
//   PW must equal QW+UW so the product always fits.
// Revision    : 1.0 - initial release
// ============================================================================
module inventory_txn_sequencer #(
    parameter int QW = 4,
    parameter int UW = 4,
    parameter int PW = 8
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    input  wire logic                      init_load,
    input  wire logic [QW-1:0]             init_count,
    input  wire logic [PW-1:0]             init_balance,
    inventory_txn_sequencer_if.slave       bus,
    output logic      [QW-1:0]             count,
    output logic      [PW-1:0]             balance,
    output logic                           empty
);

    localparam int SW = (QW > 1) ? $clog2(QW) : 1;
    localparam logic [SW-1:0] c_last_step = SW'(QW - 1);
    localparam logic [1:0] c_st_ok       = 2'd0;
    localparam logic [1:0] c_st_no_stock = 2'd1;
    localparam logic [1:0] c_st_no_funds = 2'd2;
    localparam logic [1:0] c_st_overflow = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_EVAL = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_accept;

    logic          r_op;
    logic [QW-1:0] r_qty;
    logic [UW-1:0] r_uprice;
    logic [PW-1:0] r_acc;
    logic [SW-1:0] r_step;
    logic [QW-1:0] r_count;
    logic [PW-1:0] r_balance;
    logic [1:0]    r_rsp_status;
    logic [PW-1:0] r_rsp_price;

    logic [PW-1:0] w_addend;
    logic [QW:0]   w_cnt_sum;
    logic [PW:0]   w_bal_sum;
    logic [1:0]    w_status;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = !init_load;
                w_accept      = bus.req_valid && !init_load;
                if (w_accept) begin
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (r_step == c_last_step) begin
                    w_state_next = S_EVAL;
                end
            end
            S_EVAL: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Multiplier step and evaluation arithmetic
    // ------------------------------------------------------------------
    assign w_addend  = PW'(r_uprice) << r_step;
    // Extra MSB on each sum is the overflow flag; the low bits double as
    // the committed value so no separate adder is needed.
    assign w_cnt_sum = {1'b0, r_count} + {1'b0, r_qty};
    assign w_bal_sum = {1'b0, r_balance} + {1'b0, r_acc};

    always_comb begin
        w_status = c_st_ok;
        if (r_op && (r_qty > r_count)) begin
            w_status = c_st_no_stock;
        end else if (!r_op && (r_acc > r_balance)) begin
            w_status = c_st_no_funds;
        end else if (!r_op && w_cnt_sum[QW]) begin
            w_status = c_st_overflow;
        end else if (r_op && w_bal_sum[PW]) begin
            w_status = c_st_overflow;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op         <= 1'b0;
            r_qty        <= '0;
            r_uprice     <= '0;
            r_acc        <= '0;
            r_step       <= '0;
            r_count      <= '0;
            r_balance    <= '0;
            r_rsp_status <= '0;
            r_rsp_price  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (init_load) begin
                        r_count   <= init_count;
                        r_balance <= init_balance;
                    end else if (w_accept) begin
                        r_op     <= bus.req_op;
                        r_qty    <= bus.req_qty;
                        r_uprice <= bus.req_uprice;
                        r_acc    <= '0;
                        r_step   <= '0;
                    end
                end
                S_MUL: begin
                    if (r_qty[r_step]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_step <= r_step + SW'(1);
                end
                S_EVAL: begin
                    r_rsp_status <= w_status;
                    r_rsp_price  <= r_acc;
                    if (w_status == c_st_ok) begin
                        if (r_op) begin
                            r_count   <= r_count - r_qty;
                            r_balance <= w_bal_sum[PW-1:0];
                        end else begin
                            r_count   <= w_cnt_sum[QW-1:0];
                            r_balance <= r_balance - r_acc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rsp_status = r_rsp_status;
    assign bus.rsp_price  = r_rsp_price;
    assign count          = r_count;
    assign balance        = r_balance;
    assign empty          = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_inventory_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_inventory_txn_sequencer
// Description : Self-checking bench for inventory_txn_sequencer. A reference
//               model tracks count/balance with integer arithmetic and
//               predicts status, price and latency of every transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inventory_txn_sequencer;

    localparam int QW = 4;
    localparam int UW = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_load;
    logic [QW-1:0] init_count;
    logic [PW-1:0] init_balance;
    logic [QW-1:0] count;
    logic [PW-1:0] balance;
    logic          empty;

    inventory_txn_sequencer_if #(.QW(QW), .UW(UW), .PW(PW)) bus ();

    inventory_txn_sequencer #(.QW(QW), .UW(UW), .PW(PW)) dut (
        .clk          (clk),
        .reset        (reset),
        .init_load    (init_load),
        .init_count   (init_count),
        .init_balance (init_balance),
        .bus          (bus.slave),
        .count        (count),
        .balance      (balance),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int m_count = 0;
    int m_balance = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: price is plain multiplication; rules applied in priority order.
    task automatic model_txn(input bit op, input int qty, input int up,
                             output int st, output int pr);
        pr = qty * up;
        if (op && qty > m_count)                         st = 1;
        else if (!op && pr > m_balance)                  st = 2;
        else if (!op && m_count + qty > (1 << QW) - 1)   st = 3;
        else if (op && m_balance + pr > (1 << PW) - 1)   st = 3;
        else begin
            st = 0;
            if (op) begin m_count -= qty; m_balance += pr; end
            else    begin m_count += qty; m_balance -= pr; end
        end
    endtask

    task automatic do_load(input int c, input int b);
        init_load    = 1'b1;
        init_count   = QW'(c);
        init_balance = PW'(b);
        tick();
        init_load = 1'b0;
        m_count   = c;
        m_balance = b;
        n_cmp++;
        if (count !== QW'(c) || balance !== PW'(b)) begin
            n_err++;
            $display("FAIL load: count=%0d balance=%0d expected %0d/%0d", count, balance, c, b);
        end
    endtask

    task automatic do_txn(input string name, input bit op, input int qty, input int up,
                          input int hold, input bit pre, input bit noise);
        int st_e, pr_e, w, lat, rr_bad;
        logic [1:0]    st_s;
        logic [PW-1:0] pr_s;
        #1;
        model_txn(op, qty, up, st_e, pr_e);
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 20) begin tick(); w++; end
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s req_ready: got %b expected 1", name, bus.req_ready);
        end
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_qty    = QW'(qty);
        bus.req_uprice = UW'(up);
        bus.rsp_ready  = pre;
        tick();
        bus.req_valid  = 1'b0;
        bus.req_op     = 1'($urandom);
        bus.req_qty    = QW'($urandom);
        bus.req_uprice = UW'($urandom);
        lat = 0;
        rr_bad = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            if (bus.req_ready !== 1'b0) rr_bad++;
            if (noise) begin
                init_load    = 1'b1;
                init_count   = QW'($urandom);
                init_balance = PW'($urandom);
            end
            tick();
            lat++;
        end
        init_load = 1'b0;
        n_cmp++;
        if (lat != QW + 1) begin
            n_err++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, QW + 1);
        end
        n_cmp++;
        if (rr_bad != 0) begin
            n_err++;
            $display("FAIL %s busy req_ready: got %0d high cycles expected 0", name, rr_bad);
        end
        n_cmp++;
        if (bus.rsp_status !== 2'(st_e) || bus.rsp_price !== PW'(pr_e)) begin
            n_err++;
            $display("FAIL %s response: status=%0d price=%0d expected %0d/%0d",
                     name, bus.rsp_status, bus.rsp_price, st_e, pr_e);
        end
        n_cmp++;
        if (count !== QW'(m_count) || balance !== PW'(m_balance) || empty !== (m_count == 0)) begin
            n_err++;
            $display("FAIL %s state: count=%0d balance=%0d empty=%b expected %0d/%0d/%b",
                     name, count, balance, empty, m_count, m_balance, m_count == 0);
        end
        if (!pre) begin
            st_s = bus.rsp_status;
            pr_s = bus.rsp_price;
            for (int i = 0; i < hold; i++) begin
                tick();
                n_cmp++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== st_s || bus.rsp_price !== pr_s
                    || bus.req_ready !== 1'b0 || count !== QW'(m_count)) begin
                    n_err++;
                    $display("FAIL %s hold%0d: valid=%b status=%0d price=%0d req_ready=%b expected 1/%0d/%0d/0",
                             name, i, bus.rsp_valid, bus.rsp_status, bus.rsp_price, bus.req_ready, st_s, pr_s);
                end
            end
            bus.rsp_ready = 1'b1;
        end
        tick();
        bus.rsp_ready = 1'b0;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s after handshake: rsp_valid=%b req_ready=%b expected 0/1",
                     name, bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_count = 0;
        m_balance = 0;
        n_cmp++;
        if (count !== '0 || balance !== '0 || empty !== 1'b1 || bus.rsp_valid !== 1'b0
            || bus.rsp_status !== 2'd0 || bus.rsp_price !== '0 || bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset: count=%0d balance=%0d empty=%b rsp_valid=%b req_ready=%b expected 0/0/1/0/1",
                     count, balance, empty, bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_directed();
        do_load(10, 50);
        do_txn("sell_ok", 1'b1, 3, 5, 0, 1'b0, 1'b0);
        n_cmp++;
        if (count !== 4'd7 || balance !== 8'd65) begin
            n_err++;
            $display("FAIL sell_ok_abs: count=%0d balance=%0d expected 7/65", count, balance);
        end
        do_load(2, 100);
        do_txn("no_stock", 1'b1, 3, 4, 0, 1'b0, 1'b0);
        do_load(1, 20);
        do_txn("no_funds", 1'b0, 5, 5, 0, 1'b0, 1'b0);
        do_txn("restock_ok", 1'b0, 4, 5, 0, 1'b0, 1'b0);
        do_load(14, 200);
        do_txn("cnt_ovf", 1'b0, 3, 1, 0, 1'b0, 1'b0);
        do_load(15, 30);
        do_txn("sell_to_empty", 1'b1, 15, 15, 0, 1'b1, 1'b0);
        do_load(15, 31);
        do_txn("bal_ovf", 1'b1, 15, 15, 0, 1'b0, 1'b0);
        do_load(0, 9);
        do_txn("sell_qty0", 1'b1, 0, 7, 0, 1'b0, 1'b0);
        do_txn("restock_up0", 1'b0, 6, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_hold();
        do_load(8, 40);
        do_txn("hold6", 1'b1, 2, 9, 6, 1'b0, 1'b0);
    endtask

    task automatic test_init_during_mul();
        do_load(6, 60);
        do_txn("init_in_mul", 1'b0, 3, 7, 1, 1'b0, 1'b1);
    endtask

    task automatic test_load_and_req();
        init_load      = 1'b1;
        init_count     = 4'd9;
        init_balance   = 8'd77;
        bus.req_valid  = 1'b1;
        bus.req_op     = 1'b1;
        bus.req_qty    = 4'd2;
        bus.req_uprice = 4'd3;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL load_req ready: got %b expected 0", bus.req_ready);
        end
        tick();
        init_load = 1'b0;
        m_count   = 9;
        m_balance = 77;
        n_cmp++;
        if (count !== 4'd9 || balance !== 8'd77) begin
            n_err++;
            $display("FAIL load_req load: count=%0d balance=%0d expected 9/77", count, balance);
        end
        do_txn("load_then_req", 1'b1, 2, 3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_load(3, 100);
        do_txn("b2b_1", 1'b0, 5, 3, 0, 1'b1, 1'b0);
        do_txn("b2b_2", 1'b1, 4, 11, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int seen;
        do_load(5, 40);
        bus.req_valid  = 1'b1;
        bus.req_op     = 1'b1;
        bus.req_qty    = 4'd2;
        bus.req_uprice = 4'd3;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_count = 0;
        m_balance = 0;
        n_cmp++;
        if (count !== '0 || balance !== '0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1
            || empty !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: count=%0d balance=%0d rsp_valid=%b req_ready=%b expected 0/0/0/1",
                     count, balance, bus.rsp_valid, bus.req_ready);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.rsp_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL reset_mid rsp: got %0d valid cycles expected 0", seen);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) do_load($urandom_range(0, 15), $urandom_range(0, 255));
            do_txn("random", 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        reset          = 1'b1;
        init_load      = 1'b0;
        init_count     = '0;
        init_balance   = '0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 1'b0;
        bus.req_qty    = '0;
        bus.req_uprice = '0;
        bus.rsp_ready  = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_init_during_mul();
        test_load_and_req();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inventory_txn_sequencer.md
Name: inventory_txn_sequencer

Overview:
- Sequential front end for the combinational inventory/cash update path. It holds the stock count and cash balance in registers and accepts one sell or restock request at a time over a valid/ready handshake.
- It computes price = qty × unit_price with a bit-serial shift-add multiplier, then checks stock and funds. It commits the new count and balance atomically and returns a status over a second valid/ready handshake.
- It is the initiating/stateful counterpart that owns the state the combinational block only transforms.

Parameters:
- QW, 4, width of quantity and stock count
- UW, 4, width of unit price
- PW, 8, width of price and balance; must equal QW+UW

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- init_load  in  1  load count/balance from init_* (honoured only in IDLE)
- init_count  in  QW  initial stock count
- init_balance  in  PW  initial cash balance
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  1  1 = sell (count−qty, balance+price); 0 = restock (count+qty, balance−price)
- req_qty  in  QW  quantity
- req_uprice  in  UW  unit price
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_status  out  2  0 OK, 1 NO_STOCK, 2 NO_FUNDS, 3 OVERFLOW
- rsp_price  out  PW  computed price (valid even when rejected)
- count  out  QW  current stock count
- balance  out  PW  current cash balance
- empty  out  1  count == 0 (combinational from count register)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state = IDLE, count = 0, balance = 0, rsp_valid = 0, rsp_status = 0, rsp_price = 0, multiplier registers = 0. empty = 1 during reset.
- Reset mid-operation aborts the transaction. No commit occurs and no response is issued.
- States: IDLE, MUL, EVAL, RESP.
- IDLE:
  - req_ready = !init_load.
  - init_load has priority: count ← init_count, balance ← init_balance; any request that cycle is not accepted.
  - On req_valid && req_ready: latch op, qty, uprice; clear accumulator; step counter ← 0; go to MUL.
- MUL: exactly QW cycles. Each cycle, if qty bit[step] = 1, acc += uprice << step. step++. After step QW−1, go to EVAL.
  - The product never exceeds PW bits; no overflow is possible.
  - req_ready = 0 in every non-IDLE state. init_load is ignored in every non-IDLE state.
- EVAL (one cycle): evaluate status in this priority order:
  - sell and qty > count → NO_STOCK
  - restock and price > balance → NO_FUNDS
  - restock and count + qty > 2^QW − 1 → OVERFLOW
  - sell and balance + price > 2^PW − 1 → OVERFLOW
  - otherwise OK
- EVAL exit: on OK, commit count and balance on the same edge that enters RESP. On any reject, leave both unchanged. Always register rsp_status and rsp_price = acc.
- RESP: rsp_valid = 1 and the rsp_* outputs are held stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE and drop rsp_valid next cycle.
  - Back-to-back throughput: a new request can be accepted on the cycle after the response handshake.
- Latency: with accept at edge E0, rsp_valid is first high after edge E0+QW+1 (E5 for the defaults). count/balance change at that same edge.
- qty = 0 or uprice = 0: price 0 and status OK (unless qty=0 sell never fails; restock of 0 is OK). Count and balance are unchanged in value.
- Sell that drives count to 0 → empty rises with rsp_valid.
- Holding rsp_ready high in advance is legal; the handshake completes in the first RESP cycle.

Test Plan:
- Reset, then init_load count=10, balance=50; sell qty=3, uprice=5 → after 5 edges rsp_valid=1, status=OK, price=15, count=7, balance=65, empty=0.
- count=2, balance=100; sell qty=3, uprice=4 → status=NO_STOCK, price=12, count=2, balance=100 unchanged.
- count=1, balance=20; restock qty=5, uprice=5 → status=NO_FUNDS, price=25; then restock qty=4, uprice=5 → OK, count=5, balance=0.
- count=14, balance=200; restock qty=3, uprice=1 → OVERFLOW, unchanged. count=15, balance=30; sell qty=15, uprice=15 → price=225, balance+price=255 → OK, count=0, empty=1.
- Hold rsp_ready=0 for 6 cycles → rsp_* stable and req_ready=0 throughout. Assert init_load during MUL → ignored. In IDLE, assert init_load and req_valid together → load taken, request accepted next cycle.
- Assert reset during MUL of a sell qty=2, uprice=3 → next cycle IDLE, count=0, balance=0, rsp_valid never asserted.
